match_sequencer: RTL and testbench

MATCH_SEQUENCER -- requirements
Module: match_sequencer

---
 rtl/game_pkg.sv | 30 +++
 rtl/frame_tick_gen.sv | 28 ++
 rtl/match_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_match_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state and winner encodings, default game timing constants
package game_pkg;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SERVE = 3'd2,
    ST_PLAY  = 3'd3,
    ST_POINT = 3'd4,
    ST_PAUSE = 3'd5,
    ST_OVER  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

  localparam int DEF_WIN_SCORE    = 7;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_POINT_FRAMES = 90;
  localparam int DEF_BOOT_CYCLES  = 2500000;
  localparam int FRAME_CNT_W      = 16;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - two-flop vsync synchroniser with one-clk pulse on each falling edge
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vsync_in,
  output logic frame_tick
);

  logic [1:0] r_sync;
  logic       r_prev;
  logic       r_tick;

  // Sync chain resets high (vsync idle level) so release never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
      r_tick <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], vsync_in};
      r_prev <= r_sync[1];
      r_tick <= r_prev & ~r_sync[1];
    end
  end

  assign frame_tick = r_tick;

endmodule

// File: rtl/match_sequencer.sv
// rtl/match_sequencer.sv - game flow FSM: boot, serve, play, point, over; PAUSE_EN enables pause
module match_sequencer
  import game_pkg::*;
#(
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int POINT_FRAMES = DEF_POINT_FRAMES,
  parameter int BOOT_CYCLES  = DEF_BOOT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       goal_p1,
  input  logic       goal_p2,
  output logic       frame_tick,
  output logic       phys_run,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [7:0] p1_score,
  output logic [7:0] p2_score,
  output logic [2:0] state_o,
  output logic [1:0] winner
);

  localparam int BOOT_W = (BOOT_CYCLES < 1) ? 1 : $clog2(BOOT_CYCLES + 1);
  localparam logic [BOOT_W-1:0]      BOOT_LAST  = BOOT_W'(BOOT_CYCLES);
  localparam logic [FRAME_CNT_W-1:0] SERVE_LAST = FRAME_CNT_W'(SERVE_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] POINT_LAST = FRAME_CNT_W'(POINT_FRAMES - 1);
  localparam logic [7:0]             WIN_VAL    = 8'(WIN_SCORE);

  logic                   w_tick;
  logic                   w_start_press;
  logic                   w_pause_press;
  logic                   r_start_prev;
  state_t                 r_state;
  state_t                 w_state_next;
  logic [BOOT_W-1:0]      r_boot_cnt;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic [7:0]             r_p1_score;
  logic [7:0]             r_p2_score;
  winner_t                r_winner;
  logic                   r_serve_dir;
  logic                   r_phys_run;
  logic                   r_ball_reset;
  logic                   w_score_p1;
  logic                   w_score_p2;
  logic                   w_clear_game;
  logic                   w_set_winner;

  frame_tick_gen u_frame_tick_gen (
    .clk        (clk),
    .rst        (rst),
    .vsync_in   (vsync_in),
    .frame_tick (w_tick)
  );

  assign w_start_press = w_tick & start_btn & ~r_start_prev;

`ifdef PAUSE_EN
  logic r_pause_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pause_prev <= 1'b0;
    end else if (w_tick) begin
      r_pause_prev <= pause_btn;
    end
  end

  assign w_pause_press = w_tick & pause_btn & ~r_pause_prev;
`else
  logic w_unused_pause;
  assign w_unused_pause = pause_btn;
  assign w_pause_press  = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_score_p1   = 1'b0;
    w_score_p2   = 1'b0;
    w_clear_game = 1'b0;
    w_set_winner = 1'b0;
    case (r_state)
      ST_BOOT: begin
        if (r_boot_cnt == BOOT_LAST) w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_start_press) begin
          w_state_next = ST_SERVE;
          w_clear_game = 1'b1;
        end
      end
      ST_SERVE: begin
        if (w_tick && r_frame_cnt == SERVE_LAST) w_state_next = ST_PLAY;
      end
      ST_PLAY: begin
        // Simultaneous goals are a replay: go to POINT without scoring.
        if (goal_p1 || goal_p2) begin
          w_state_next = ST_POINT;
          w_score_p1   = goal_p1 & ~goal_p2;
          w_score_p2   = goal_p2 & ~goal_p1;
        end else if (w_pause_press) begin
          w_state_next = ST_PAUSE;
        end
      end
      ST_POINT: begin
        if (w_tick && r_frame_cnt == POINT_LAST) begin
          if (r_p1_score == WIN_VAL || r_p2_score == WIN_VAL) begin
            w_state_next = ST_OVER;
            w_set_winner = 1'b1;
          end else begin
            w_state_next = ST_SERVE;
          end
        end
      end
      ST_PAUSE: begin
        if (w_pause_press) w_state_next = ST_PLAY;
      end
      ST_OVER: begin
        if (w_start_press) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_BOOT;
      r_boot_cnt   <= '0;
      r_frame_cnt  <= '0;
      r_start_prev <= 1'b0;
      r_p1_score   <= 8'd0;
      r_p2_score   <= 8'd0;
      r_winner     <= WIN_NONE;
      r_serve_dir  <= 1'b0;
      r_phys_run   <= 1'b0;
      r_ball_reset <= 1'b1;
    end else begin
      r_state <= w_state_next;

      if (r_state == ST_BOOT && w_state_next == ST_BOOT) begin
        r_boot_cnt <= r_boot_cnt + BOOT_W'(1);
      end

      if (w_state_next != r_state) begin
        r_frame_cnt <= '0;
      end else if (w_tick && (r_state == ST_SERVE || r_state == ST_POINT)) begin
        r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
      end

      if (w_tick) r_start_prev <= start_btn;

      if (w_clear_game) begin
        r_p1_score <= 8'd0;
        r_p2_score <= 8'd0;
        r_winner   <= WIN_NONE;
      end

      // Next serve goes toward whoever conceded.
      if (w_score_p1) begin
        r_p1_score  <= sat_inc(r_p1_score);
        r_serve_dir <= 1'b1;
      end
      if (w_score_p2) begin
        r_p2_score  <= sat_inc(r_p2_score);
        r_serve_dir <= 1'b0;
      end

      if (w_set_winner) begin
        r_winner <= (r_p1_score == WIN_VAL) ? WIN_P1 : WIN_P2;
      end

      r_phys_run   <= (w_state_next == ST_PLAY);
      r_ball_reset <= (w_state_next == ST_BOOT) || (w_state_next == ST_IDLE) ||
                      (w_state_next == ST_SERVE) || (w_state_next == ST_OVER);
    end
  end

  assign frame_tick = w_tick;
  assign phys_run   = r_phys_run;
  assign ball_reset = r_ball_reset;
  assign serve_dir  = r_serve_dir;
  assign p1_score   = r_p1_score;
  assign p2_score   = r_p2_score;
  assign state_o    = r_state;
  assign winner     = r_winner;

endmodule

// File: tb/tb_match_sequencer.sv
// tb/tb_match_sequencer.sv - directed bench for match_sequencer; pause section follows PAUSE_EN
module tb_match_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync_in;
  logic       start_btn;
  logic       pause_btn;
  logic       goal_p1;
  logic       goal_p2;
  logic       frame_tick;
  logic       phys_run;
  logic       ball_reset;
  logic       serve_dir;
  logic [7:0] p1_score;
  logic [7:0] p2_score;
  logic [2:0] state_o;
  logic [1:0] winner;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [2:0] S_BOOT = 3'd0, S_IDLE = 3'd1, S_SERVE = 3'd2, S_PLAY = 3'd3,
                         S_POINT = 3'd4, S_PAUSE = 3'd5, S_OVER = 3'd6;

  always #5 clk = ~clk;

  match_sequencer #(
    .WIN_SCORE    (2),
    .SERVE_FRAMES (3),
    .POINT_FRAMES (2),
    .BOOT_CYCLES  (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vsync_in   (vsync_in),
    .start_btn  (start_btn),
    .pause_btn  (pause_btn),
    .goal_p1    (goal_p1),
    .goal_p2    (goal_p2),
    .frame_tick (frame_tick),
    .phys_run   (phys_run),
    .ball_reset (ball_reset),
    .serve_dir  (serve_dir),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .state_o    (state_o),
    .winner     (winner)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic pulse_vsync();
    @(negedge clk);
    vsync_in = 1'b0;
    repeat (6) @(negedge clk);
    vsync_in = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) pulse_vsync();
  endtask

  task automatic goal(input logic a, input logic b);
    @(negedge clk);
    goal_p1 = a;
    goal_p2 = b;
    @(negedge clk);
    goal_p1 = 1'b0;
    goal_p2 = 1'b0;
  endtask

  initial begin
    bit got_tick;
    rst = 1'b1; vsync_in = 1'b1; start_btn = 1'b0; pause_btn = 1'b0;
    goal_p1 = 1'b0; goal_p2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", state_o, S_BOOT);
    check("rst_ball_reset", ball_reset, 1);
    check("rst_phys_run", phys_run, 0);
    check("rst_scores", {p1_score, p2_score}, 0);
    check("rst_winner", winner, 0);
    check("rst_serve_dir", serve_dir, 0);
    check("rst_frame_tick", frame_tick, 0);

    rst = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check("boot_ball_reset", ball_reset, 1);
      if (k == 10) check("boot_still_boot_c10", state_o, S_BOOT);
      if (k == 11) check("boot_idle_c11", state_o, S_IDLE);
    end

    start_btn = 1'b1;
    pulse_vsync();
    check("start_to_serve", state_o, S_SERVE);
    start_btn = 1'b0;
    frames(2);
    check("serve_after_2", state_o, S_SERVE);
    check("serve_ball_reset", ball_reset, 1);
    check("serve_no_run", phys_run, 0);

    @(negedge clk);
    vsync_in = 1'b0;
    got_tick = 1'b0;
    for (int k = 0; k < 10 && !got_tick; k++) begin
      @(negedge clk);
      if (frame_tick) got_tick = 1'b1;
    end
    check("serve_tick3_seen", got_tick, 1);
    check("run_low_at_tick", phys_run, 0);
    @(negedge clk);
    check("run_high_tick_plus1", phys_run, 1);
    check("play_state", state_o, S_PLAY);
    check("play_ball_free", ball_reset, 0);
    vsync_in = 1'b1;
    repeat (6) @(negedge clk);

    goal(1'b0, 1'b1);
    check("g2_p2_score", p2_score, 1);
    check("g2_p1_score", p1_score, 0);
    check("g2_serve_dir", serve_dir, 0);
    check("g2_state", state_o, S_POINT);
    check("g2_no_run", phys_run, 0);
    frames(2);
    check("point_to_serve", state_o, S_SERVE);
    frames(3);
    check("serve_to_play_2", state_o, S_PLAY);

    goal(1'b1, 1'b1);
    check("replay_scores", {p1_score, p2_score}, 16'h0001);
    check("replay_state", state_o, S_POINT);
    check("replay_serve_dir", serve_dir, 0);
    frames(5);
    check("replay_back_play", state_o, S_PLAY);

`ifdef PAUSE_EN
    pause_btn = 1'b1;
    pulse_vsync();
    check("pause_state", state_o, S_PAUSE);
    check("pause_no_run", phys_run, 0);
    pause_btn = 1'b0;
    pulse_vsync();
    goal(1'b1, 1'b0);
    check("pause_goal_ignored", p1_score, 0);
    check("pause_held", state_o, S_PAUSE);
    pause_btn = 1'b1;
    pulse_vsync();
    check("resume_state", state_o, S_PLAY);
    check("resume_run", phys_run, 1);
    pause_btn = 1'b0;
    pulse_vsync();
`else
    pause_btn = 1'b1;
    pulse_vsync();
    check("pause_ignored_state", state_o, S_PLAY);
    check("pause_ignored_run", phys_run, 1);
    pause_btn = 1'b0;
    pulse_vsync();
`endif

    goal(1'b1, 1'b0);
    check("g1_p1_score", p1_score, 1);
    check("g1_serve_dir", serve_dir, 1);
    check("g1_state", state_o, S_POINT);
    frames(5);
    check("g1_back_play", state_o, S_PLAY);
    goal(1'b1, 1'b0);
    check("g1b_p1_score", p1_score, 2);
    goal(1'b0, 1'b1);
    check("point_goal_ignored", p2_score, 1);
    check("winner_not_yet", winner, 0);
    frames(2);
    check("over_state", state_o, S_OVER);
    check("over_winner", winner, 1);
    check("over_ball_reset", ball_reset, 1);

    start_btn = 1'b1;
    pulse_vsync();
    check("over_to_idle", state_o, S_IDLE);
    start_btn = 1'b0;
    pulse_vsync();
    start_btn = 1'b1;
    pulse_vsync();
    check("new_game_serve", state_o, S_SERVE);
    check("new_game_scores", {p1_score, p2_score}, 0);
    check("new_game_winner", winner, 0);
    start_btn = 1'b0;

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_state", state_o, S_BOOT);
    check("mid_rst_ball_reset", ball_reset, 1);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
